// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller: FSM state encoding and
// sweep-direction constants.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/scan_dir_select.sv
// Combinational call locator: reports outstanding calls above, below and at the
// current floor, plus whether any call lies ahead in the present sweep direction.
module scan_dir_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here,
    output logic                  ahead
);

    logic [NUM_FLOORS-1:0] above_bits;
    logic [NUM_FLOORS-1:0] below_bits;

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign above_bits[gi] = pending[gi] && (FLOOR_W'(gi) > current_floor);
            assign below_bits[gi] = pending[gi] && (FLOOR_W'(gi) < current_floor);
        end
    endgenerate

    assign any_above = |above_bits;
    assign any_below = |below_bits;
    assign here      = pending[current_floor];
    assign ahead     = (dir_up == DIR_UP) ? any_above : any_below;

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-policy elevator controller: latched per-floor calls, counter-timed travel
// and door phases, sweep direction retained while idle.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS),
    parameter int MOVE_DELAY = 150000000,
    parameter int DOOR_DELAY = 250000000,
    parameter int CNT_W      = 29
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  floor_reached,
    output logic                  dir_up
);

    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_DELAY - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_DELAY - 1);

    state_t                  state_reg,   state_next;
    logic [FLOOR_W-1:0]      floor_reg,   floor_next;
    logic [CNT_W-1:0]        cnt_reg,     cnt_next;
    logic [NUM_FLOORS-1:0]   pend_reg,    pend_next;
    logic                    dir_reg,     dir_next;
    logic                    reached_reg, reached_next;
    logic [NUM_FLOORS-1:0]   clear;
    logic [FLOOR_W-1:0]      step_floor;
    logic                    any_above;
    logic                    any_below;
    logic                    here;
    logic                    ahead;
    logic                    behind;

    scan_dir_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_dir_select (
        .pending       (pend_reg),
        .current_floor (floor_reg),
        .dir_up        (dir_reg),
        .any_above     (any_above),
        .any_below     (any_below),
        .here          (here),
        .ahead         (ahead)
    );

    assign behind = (dir_reg == DIR_UP) ? any_below : any_above;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            floor_reg   <= '0;
            cnt_reg     <= '0;
            pend_reg    <= '0;
            dir_reg     <= DIR_UP;
            reached_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            floor_reg   <= floor_next;
            cnt_reg     <= cnt_next;
            pend_reg    <= pend_next;
            dir_reg     <= dir_next;
            reached_reg <= reached_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        floor_next   = floor_reg;
        cnt_next     = cnt_reg;
        dir_next     = dir_reg;
        reached_next = 1'b0;
        clear        = '0;
        step_floor   = (dir_reg == DIR_UP) ? floor_reg + FLOOR_W'(1) : floor_reg - FLOOR_W'(1);

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (here) begin
                    state_next       = ST_DOOR;
                    clear[floor_reg] = 1'b1;
                    reached_next     = 1'b1;
                end else if (ahead) begin
                    state_next = ST_MOVING;
                end else if (behind) begin
                    state_next = ST_MOVING;
                    dir_next   = (dir_reg == DIR_UP) ? DIR_DOWN : DIR_UP;
                end
            end

            ST_MOVING: begin
                if (cnt_reg == MOVE_LAST) begin
                    cnt_next = '0;
                    // Only step toward an outstanding call; this also keeps the
                    // car inside 0..NUM_FLOORS-1.
                    if (!ahead) begin
                        state_next = ST_IDLE;
                    end else begin
                        floor_next = step_floor;
                        if (pend_reg[step_floor]) begin
                            state_next        = ST_DOOR;
                            clear[step_floor] = 1'b1;
                            reached_next      = 1'b1;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_DOOR: begin
                // The open door services any call at this floor, so it never latches.
                clear[floor_reg] = 1'b1;
                if (door_hold || call_req[floor_reg]) begin
                    cnt_next = '0;
                end else if (cnt_reg == DOOR_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        pend_next = (pend_reg | call_req) & ~clear;
    end

    assign current_floor = floor_reg;
    assign pending       = pend_reg;
    assign moving_up     = (state_reg == ST_MOVING) && (dir_reg == DIR_UP);
    assign moving_down   = (state_reg == ST_MOVING) && (dir_reg == DIR_DOWN);
    assign door_open     = (state_reg == ST_DOOR);
    assign floor_reached = reached_reg;
    assign dir_up        = dir_reg;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: directed scenarios plus random calls, every
// cycle compared against a countdown-based behavioural model of the car.
module tb_elevator_scan_controller;

    localparam int NF = 8;
    localparam int MD = 4;
    localparam int DD = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] call_req;
    logic          door_hold;
    logic [2:0]    current_floor;
    logic [NF-1:0] pending;
    logic          moving_up;
    logic          moving_down;
    logic          door_open;
    logic          floor_reached;
    logic          dir_up;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int overrun  = 0;
    int served[$];

    // Behavioural model: car position, call set, and cycles left in current leg.
    int      m_floor = 0;
    bit [7:0] m_pend = '0;
    bit      m_up     = 1'b1;
    bit      m_travel = 1'b0;
    bit      m_door   = 1'b0;
    bit      m_pulse  = 1'b0;
    int      m_left   = 0;

    elevator_scan_controller #(
        .NUM_FLOORS (NF),
        .MOVE_DELAY (MD),
        .DOOR_DELAY (DD),
        .CNT_W      (29)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call_req      (call_req),
        .door_hold     (door_hold),
        .current_floor (current_floor),
        .pending       (pending),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open),
        .floor_reached (floor_reached),
        .dir_up        (dir_up)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic bit calls_beyond(input bit [7:0] p, input int f, input bit up);
        for (int i = 0; i < NF; i++)
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit r, input bit [7:0] call, input bit hold);
        bit [7:0] np;
        if (!r) begin
            m_floor = 0; m_pend = '0; m_up = 1'b1;
            m_travel = 1'b0; m_door = 1'b0; m_pulse = 1'b0; m_left = 0;
            return;
        end
        np      = m_pend | call;
        m_pulse = 1'b0;
        if (m_door) begin
            np[m_floor] = 1'b0;
            if (hold || call[m_floor]) m_left = DD;
            else begin
                m_left--;
                if (m_left == 0) m_door = 1'b0;
            end
        end else if (m_travel) begin
            m_left--;
            if (m_left == 0) begin
                m_floor += m_up ? 1 : -1;
                if (m_pend[m_floor]) begin
                    np[m_floor] = 1'b0; m_travel = 1'b0; m_door = 1'b1;
                    m_pulse = 1'b1; m_left = DD;
                end else m_left = MD;
            end
        end else begin
            if (m_pend[m_floor]) begin
                np[m_floor] = 1'b0; m_door = 1'b1; m_pulse = 1'b1; m_left = DD;
            end else if (calls_beyond(m_pend, m_floor, m_up)) begin
                m_travel = 1'b1; m_left = MD;
            end else if (calls_beyond(m_pend, m_floor, !m_up)) begin
                m_up = !m_up; m_travel = 1'b1; m_left = MD;
            end
        end
        m_pend = np;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, call_req, door_hold);
        #1;
        cycle++;
        check_val("floor", 32'(current_floor), m_floor);
        check_val("pending", 32'(pending), 32'(m_pend));
        check_val("flags", {27'd0, moving_up, moving_down, door_open, floor_reached, dir_up},
                  {27'd0, m_travel && m_up, m_travel && !m_up, m_door, m_pulse, m_up});
        if (floor_reached) begin
            served.push_back(int'(current_floor));
            $display("serve floor %0d at cycle %0d", current_floor, cycle);
        end
        if (current_floor == 3'd7 && moving_up) overrun++;
    endtask

    task automatic post(input logic [NF-1:0] mask);
        call_req = mask;
        tick();
        call_req = '0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (pending == '0) && !moving_up && !moving_down && !door_open;
        end
        check_val("idle_reached", 32'(done), 1);
    endtask

    task automatic wait_floor(input int f, input int budget);
        int n = 0;
        while (int'(current_floor) != f && n < budget) begin
            tick();
            n++;
        end
        check_val("floor_wait", 32'(current_floor), f);
    endtask

    initial begin
        int n;
        int exp_scan[3] = '{4, 5, 0};
        int exp_route[2] = '{4, 6};

        rst = 1'b0; call_req = '0; door_hold = 1'b0;

        // Reset
        tick(); tick();
        check_val("rst_floor", 32'(current_floor), 0);
        check_val("rst_pending", 32'(pending), 0);
        check_val("rst_flags", {27'd0, moving_up, moving_down, door_open, floor_reached, dir_up}, 32'd1);
        rst = 1'b1;
        tick();

        // Single call 0 -> 3: arrival 13 edges after the request edge, door 6 cycles
        post(8'h08);
        n = 0;
        do begin tick(); n++; end while (!floor_reached && n < 100);
        check_val("single_arrive", n, 13);
        check_val("single_floor", 32'(current_floor), 3);
        n = 1;
        while (door_open && n < 50) begin
            tick();
            if (door_open) n++;
        end
        check_val("single_door", n, DD);
        check_val("single_pending", 32'(pending), 0);

        // SCAN order: go to 0, then head for 4; at floor 2 post 5 and 0
        post(8'h01);
        run_until_idle(500);
        served.delete();
        post(8'h10);
        wait_floor(2, 200);
        check_val("scan_dir_at2", 32'(moving_up), 1);
        post(8'h21);
        run_until_idle(1000);
        check_val("scan_count", served.size(), 3);
        for (int i = 0; i < 3 && i < served.size(); i++) check_val("scan_order", served[i], exp_scan[i]);
        check_val("scan_dir_end", 32'(dir_up), 0);

        // En-route pickup: 0 -> 6 with call 4 posted at floor 1
        served.delete();
        post(8'h40);
        wait_floor(1, 200);
        post(8'h10);
        run_until_idle(1000);
        check_val("route_count", served.size(), 2);
        for (int i = 0; i < 2 && i < served.size(); i++) check_val("route_order", served[i], exp_route[i]);

        // Door extension at floor 6: hold 10 cycles then a re-call
        post(8'h40);
        n = 0;
        while (!door_open && n < 20) begin tick(); n++; end
        check_val("ext_opened", 32'(door_open), 1);
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("ext_hold_open", 32'(door_open), 1);
        end
        door_hold = 1'b0;
        post(8'h40);
        n = 0;
        while (door_open && n < 50) begin tick(); n++; end
        check_val("ext_after_last", n, DD);
        check_val("ext_pending", 32'(pending), 0);

        // Top boundary: 0 -> 7
        post(8'h01);
        run_until_idle(1000);
        post(8'h80);
        run_until_idle(1000);
        check_val("top_floor", 32'(current_floor), 7);
        check_val("top_overrun", overrun, 0);

        // Reset while moving
        post(8'h09);
        for (int i = 0; i < 5; i++) tick();
        check_val("mid_moving", 32'(moving_down), 1);
        rst = 1'b0;
        tick();
        check_val("mid_rst_floor", 32'(current_floor), 0);
        check_val("mid_rst_pending", 32'(pending), 0);
        check_val("mid_rst_flags", {27'd0, moving_up, moving_down, door_open, floor_reached, dir_up}, 32'd1);
        rst = 1'b1;
        tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            call_req  = ($urandom_range(0, 9) == 0) ? (8'(1) << $urandom_range(0, NF - 1)) : '0;
            door_hold = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 1499) != 0);
            tick();
        end
        call_req = '0; door_hold = 1'b0; rst = 1'b1;
        run_until_idle(2000);
        check_val("rand_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
